// File: rtl/dp_sequencer.sv
// ARM data-processing sequencer: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
// Optional condition-code checking is compiled in with the DP_SEQ_COND_EN macro.
module dp_sequencer (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  input  logic [31:0] Inst,
  input  logic [3:0]  NZCV,
  input  logic [31:0] Rs_Data,
  output logic [3:0]  Rn_Addr,
  output logic [3:0]  Rm_Addr,
  output logic [3:0]  Rs_Addr,
  output logic [3:0]  Rd_Addr,
  output logic [31:0] Imm32,
  output logic        Op_Sel,
  output logic [2:0]  SHIFT_OP,
  output logic [7:0]  Shift_Num,
  output logic [3:0]  ALU_OP,
  output logic        LF,
  output logic        S,
  output logic        Write_Reg,
  output logic        Done,
  output logic        Illegal,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  // Handshake: an instruction transfers on a rising edge where Inst_Valid && Inst_Ready;
  // Inst_Ready is high only in IDLE, and Inst_Valid is ignored in every other state.
  state_t      state, state_nx;
  logic [31:0] inst_q;
  logic [7:0]  rs_q;
  logic        accept;
  logic        illegal_inst;
  logic        cond_pass;

  assign accept    = Inst_Valid && (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state  <= IDLE;
      inst_q <= '0;
      rs_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) inst_q <= Inst;
      if (state == READ) rs_q <= Rs_Data[7:0];
    end
  end

  // Non-DP encodings and the multiply/extra load-store space (bit7 & bit4 with register operand).
  assign illegal_inst = (inst_q[27:26] != 2'b00) || (!inst_q[25] && inst_q[7] && inst_q[4]);

`ifdef DP_SEQ_COND_EN
  logic cond_base;
  logic unused_bits;
  assign unused_bits = ^Rs_Data[31:8];

  // Even codes test a flag expression; odd codes invert it. 1110 is AL, 1111 never passes.
  always_comb begin
    cond_base = 1'b0;
    case (inst_q[31:29])
      3'd0: cond_base = NZCV[2];
      3'd1: cond_base = NZCV[1];
      3'd2: cond_base = NZCV[3];
      3'd3: cond_base = NZCV[0];
      3'd4: cond_base = NZCV[1] && !NZCV[2];
      3'd5: cond_base = (NZCV[3] == NZCV[0]);
      3'd6: cond_base = !NZCV[2] && (NZCV[3] == NZCV[0]);
      default: cond_base = 1'b1;
    endcase
    cond_pass = (inst_q[31:29] == 3'd7) ? !inst_q[28] : (cond_base ^ inst_q[28]);
  end
`else
  logic unused_bits;
  assign unused_bits = ^{NZCV, inst_q[31:28], Rs_Data[31:8]};
  assign cond_pass   = 1'b1;
`endif

  always_comb begin
    state_nx   = state;
    Inst_Ready = 1'b0;
    LF         = 1'b0;
    S          = 1'b0;
    Write_Reg  = 1'b0;
    Done       = 1'b0;
    Illegal    = 1'b0;
    case (state)
      IDLE: begin
        Inst_Ready = 1'b1;
        if (Inst_Valid) state_nx = READ;
      end
      READ: begin
        if (illegal_inst) begin
          Illegal  = 1'b1;
          state_nx = IDLE;
        end else if (!cond_pass) begin
          Done     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        LF       = 1'b1;
        S        = inst_q[20];
        state_nx = WB;
      end
      WB: begin
        // TST/TEQ/CMP/CMN (10xx) only update flags.
        Write_Reg = (inst_q[24:23] != 2'b10);
        Done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Rn_Addr   = '0;
    Rd_Addr   = '0;
    Rs_Addr   = '0;
    Rm_Addr   = '0;
    ALU_OP    = '0;
    Imm32     = '0;
    Op_Sel    = 1'b0;
    SHIFT_OP  = '0;
    Shift_Num = '0;
    if (state != IDLE) begin
      Rn_Addr = inst_q[19:16];
      Rd_Addr = inst_q[15:12];
      Rs_Addr = inst_q[11:8];
      Rm_Addr = inst_q[3:0];
      ALU_OP  = inst_q[24:21];
      if (inst_q[25]) begin
        Op_Sel    = 1'b1;
        Imm32     = {24'd0, inst_q[7:0]};
        SHIFT_OP  = 3'b011;
        Shift_Num = {3'b000, inst_q[11:8], 1'b0};
      end else if (!inst_q[4]) begin
        SHIFT_OP  = {1'b0, inst_q[6:5]};
        Shift_Num = {3'b000, inst_q[11:7]};
      end else begin
        // Rs is only captured at the end of READ, so READ forwards the live read data.
        SHIFT_OP  = {1'b1, inst_q[6:5]};
        Shift_Num = (state == READ) ? Rs_Data[7:0] : rs_q;
      end
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: directed instructions plus random ones against a
// per-cycle reference model. Honors DP_SEQ_COND_EN the same way the design does.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_w;
  logic [3:0]  nzcv_w;
  logic [31:0] rs_w;
  logic [3:0]  rn_addr, rm_addr, rs_addr, rd_addr;
  logic [31:0] imm32;
  logic        op_sel;
  logic [2:0]  shift_op;
  logic [7:0]  shift_num;
  logic [3:0]  alu_op;
  logic        lf, s_flag, write_reg, done, illegal;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  dp_sequencer dut (
    .clk(clk), .Rst(rst), .Inst_Valid(inst_valid), .Inst_Ready(inst_ready), .Inst(inst_w),
    .NZCV(nzcv_w), .Rs_Data(rs_w), .Rn_Addr(rn_addr), .Rm_Addr(rm_addr), .Rs_Addr(rs_addr),
    .Rd_Addr(rd_addr), .Imm32(imm32), .Op_Sel(op_sel), .SHIFT_OP(shift_op),
    .Shift_Num(shift_num), .ALU_OP(alu_op), .LF(lf), .S(s_flag), .Write_Reg(write_reg),
    .Done(done), .Illegal(illegal), .dbg_state(dbg_state)
  );

  localparam logic [5:0] C_RDY = 6'd32, C_LF = 6'd16, C_S = 6'd8, C_WR = 6'd4,
                         C_DONE = 6'd2, C_ILL = 6'd1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0]  exp_q[$];
  logic [31:0] exp_addr, exp_ops, exp_imm;
  logic [31:0] snap_ctl[4], snap_ops[4], snap_imm[4], snap_addr[4];
  logic [31:0] snap_idle;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_ctl();
    return {26'd0, inst_ready, lf, s_flag, write_reg, done, illegal};
  endfunction
  function automatic logic [31:0] obs_addr();
    return {16'd0, rn_addr, rd_addr, rs_addr, rm_addr};
  endfunction
  function automatic logic [31:0] obs_ops();
    return {16'd0, op_sel, shift_op, shift_num, alu_op};
  endfunction

  // ARM condition table as written in the architecture manual.
  function automatic bit cond_ok(input int c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      0: return z;                 1: return !z;
      2: return cf;                3: return !cf;
      4: return n;                 5: return !n;
      6: return v;                 7: return !v;
      8: return cf && !z;          9: return !cf || z;
      10: return n == v;           11: return n != v;
      12: return !z && (n == v);   13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: expected decode fields and one control word per busy cycle.
  task automatic model(input logic [31:0] i, input logic [3:0] f, input logic [31:0] rs);
    int alu, immf, b4, b7, sh, num;
    bit bad, pass;
    alu  = int'((i >> 21) & 15);
    immf = int'((i >> 25) & 1);
    b4   = int'((i >> 4) & 1);
    b7   = int'((i >> 7) & 1);
    exp_addr = (((i >> 16) & 15) << 12) | (((i >> 12) & 15) << 8) | (((i >> 8) & 15) << 4) | (i & 15);
    exp_imm  = 0;
    if (immf == 1) begin
      sh = 3; num = int'(((i >> 8) & 15) * 2); exp_imm = i & 255;
    end else if (b4 == 0) begin
      sh = int'((i >> 5) & 3); num = int'((i >> 7) & 31);
    end else begin
      sh = 4 + int'((i >> 5) & 3); num = int'(rs & 255);
    end
    exp_ops = 32'((immf << 15) | (sh << 12) | (num << 4) | alu);
    bad = (((i >> 26) & 3) != 0) || (immf == 0 && b7 == 1 && b4 == 1);
`ifdef DP_SEQ_COND_EN
    pass = cond_ok(int'(i >> 28), f);
`else
    pass = 1'b1;
`endif
    exp_q.delete();
    if (bad) exp_q.push_back(C_ILL);
    else if (!pass) exp_q.push_back(C_DONE);
    else begin
      exp_q.push_back(6'd0);
      exp_q.push_back(((i >> 20) & 1) != 0 ? (C_LF | C_S) : C_LF);
      exp_q.push_back((alu >= 8 && alu <= 11) ? C_DONE : (C_DONE | C_WR));
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"}, obs_ctl(), 32'(C_RDY));
    check_eq({tag, "_addr"}, obs_addr(), 32'd0);
    check_eq({tag, "_ops"}, obs_ops(), 32'd0);
    check_eq({tag, "_imm"}, imm32, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Offers one instruction and checks every cycle until back in IDLE; abort_cyc>0 pulses Rst there.
  task automatic run_inst(input logic [31:0] i, input logic [3:0] f, input logic [31:0] rs,
                          input int abort_cyc);
    int n_busy;
    logic [5:0] e;
    model(i, f, rs);
    n_busy = exp_q.size();
    @(posedge clk); #1;
    inst_valid = 1'b1; inst_w = i; nzcv_w = 4'($urandom); rs_w = $urandom;
    @(negedge clk);
    check_idle("offer");
    for (int c = 1; c <= n_busy; c++) begin
      @(posedge clk); #1;
      rst        = (c == abort_cyc);
      inst_valid = 1'($urandom_range(0, 1));
      inst_w     = $urandom;
      nzcv_w     = (c == 1) ? f : 4'($urandom);
      rs_w       = (c == 1) ? rs : $urandom;
      @(negedge clk);
      e = exp_q.pop_front();
      snap_ctl[c] = obs_ctl(); snap_ops[c] = obs_ops(); snap_imm[c] = imm32; snap_addr[c] = obs_addr();
      check_eq($sformatf("ctl_c%0d", c), snap_ctl[c], 32'(e));
      check_eq($sformatf("addr_c%0d", c), snap_addr[c], exp_addr);
      check_eq($sformatf("ops_c%0d", c), snap_ops[c], exp_ops);
      check_eq($sformatf("imm_c%0d", c), snap_imm[c], exp_imm);
      if (rst) break;
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    snap_idle = obs_ctl();
    check_idle("back");
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; inst_valid = 1'b0; inst_w = '0; nzcv_w = '0; rs_w = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // ADDS R1,R2,#5
    run_inst(32'hE2921005, 4'b0000, 32'h0, 0);
    check_eq("adds_exec_ops", snap_ops[2], 32'h0000B004);
    check_eq("adds_exec_imm", snap_imm[2], 32'd5);
    check_eq("adds_exec_ctl", snap_ctl[2], 32'(C_LF | C_S));
    check_eq("adds_wb_ctl", snap_ctl[3], 32'(C_WR | C_DONE));
    check_eq("adds_wb_rd", (snap_addr[3] >> 8) & 15, 32'd1);

    // CMP R3,R4
    run_inst(32'hE1530004, 4'b0000, 32'h0, 0);
    check_eq("cmp_exec_ctl", snap_ctl[2], 32'(C_LF | C_S));
    check_eq("cmp_wb_ctl", snap_ctl[3], 32'(C_DONE));

    // ADD R0,R1,R2,LSL R3 with Rs=0x105
    run_inst(32'hE0810312, 4'b0000, 32'h00000105, 0);
    check_eq("regsh_read_shift", (snap_ops[1] >> 4) & 32'h7FF, 32'h405);
    check_eq("regsh_exec_shift", (snap_ops[2] >> 4) & 32'h7FF, 32'h405);
    check_eq("regsh_rm", snap_addr[2] & 15, 32'd2);

    // MOVNE R0,#1 with Z set
    run_inst(32'h13A00001, 4'b0100, 32'h0, 0);
`ifdef DP_SEQ_COND_EN
    check_eq("movne_skip_c1", snap_ctl[1], 32'(C_DONE));
    check_eq("movne_skip_c2", snap_idle, 32'(C_RDY));
`else
    check_eq("movne_exec", snap_ctl[2], 32'(C_LF));
    check_eq("movne_wb", snap_ctl[3], 32'(C_WR | C_DONE));
`endif

    // MUL
    run_inst(32'hE0000091, 4'b0000, 32'h0, 0);
    check_eq("mul_illegal_c1", snap_ctl[1], 32'(C_ILL));

    // Reset during EXEC of ADDS
    run_inst(32'hE2921005, 4'b0000, 32'h0, 2);
    check_eq("abort_no_wr_done", snap_ctl[2] & 32'(C_WR | C_DONE), 32'd0);

    // Reset wins over a simultaneous accept
    @(posedge clk); #1;
    rst = 1'b1; inst_valid = 1'b1; inst_w = 32'hE2921005;
    @(posedge clk); #1;
    rst = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    check_idle("rst_vs_accept");

    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[27:26] = 2'b00;
      if ($urandom_range(0, 3) == 0) r[31:28] = 4'hE;
      run_inst(r, 4'($urandom), $urandom, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL have clk, input, 1, the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have Rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-003 The block SHALL have Inst_Valid, input, 1, meaning the instruction word is offered.
REQ-004 The block SHALL have Inst_Ready, output, 1, meaning the block accepts an instruction this cycle.
REQ-005 The block SHALL have Inst, input, 32, the ARM data-processing instruction word.
REQ-006 The block SHALL have NZCV, input, 4, the current flags from the datapath.
REQ-007 The block SHALL have Rs_Data, input, 32, the register-file read data for Rs.
REQ-008 The block SHALL have Rn_Addr, Rm_Addr, Rs_Addr and Rd_Addr, outputs, 4 each, the register-file addresses.
REQ-009 The block SHALL have Imm32, output, 32, the zero-extended imm8 when Op_Sel=1.
REQ-010 The block SHALL have Op_Sel, output, 1, where 1 selects Imm32 and 0 selects Rm as Shift_Data.
REQ-011 The block SHALL have SHIFT_OP, output, 3, Shift_Num, output, 8, and ALU_OP, output, 4, the datapath controls.
REQ-012 The block SHALL have LF, output, 1, the result latch enable, and S, output, 1, the flag latch enable.
REQ-013 The block SHALL have Write_Reg, Done and Illegal, outputs, 1 each.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, EXEC and WB; Inst_Ready=1 only in IDLE.
REQ-015 On Inst_Valid&&Inst_Ready the block SHALL latch Inst and go IDLE->READ.
REQ-016 If Inst[27:26]!=00, or Inst[25]=0 with Inst[7]=1 and Inst[4]=1, the block SHALL pulse Illegal for 1 cycle in READ and return to IDLE; LF, S and Write_Reg stay 0.
REQ-017 In READ the block SHALL latch Rs_Data[7:0] and evaluate the condition Inst[31:28] against NZCV.
  - pass: READ->EXEC.
  - fail: pulse Done in READ, then go to IDLE.
REQ-018 In EXEC the block SHALL assert LF=1 and S=Inst[20]; the state is EXEC->WB.
REQ-019 In WB the block SHALL assert Write_Reg=1 unless ALU_OP is 1000-1011 (TST/TEQ/CMP/CMN), pulse Done, and then go WB->IDLE.
REQ-020 Address decode: Rn_Addr=Inst[19:16], Rd_Addr=Inst[15:12], Rs_Addr=Inst[11:8], Rm_Addr=Inst[3:0].
REQ-021 ALU_OP SHALL equal Inst[24:21].
REQ-022 Operand decode SHALL be:
  - Inst[25]=1: Op_Sel=1, SHIFT_OP=011, Shift_Num={000,Inst[11:8],0}.
  - Inst[25]=0, Inst[4]=0: SHIFT_OP={0,Inst[6:5]}, Shift_Num={000,Inst[11:7]}.
  - Inst[25]=0, Inst[4]=1: SHIFT_OP={1,Inst[6:5]}, Shift_Num=latched Rs_Data[7:0].
REQ-023 The decode outputs SHALL be held stable from READ through WB and be 0 in IDLE.
REQ-024 Latency SHALL be accept at edge 0, READ in cycle 1, EXEC in cycle 2, WB with Done in cycle 3, and Inst_Ready in cycle 4; throughput is 1 instruction per 4 cycles.
REQ-025 Inst_Valid outside IDLE SHALL be ignored, and Inst changes after acceptance SHALL have no effect.

Reset
REQ-026 When Rst=1 at a rising edge, the next state SHALL be IDLE and the latched instruction SHALL be cleared.
REQ-027 After reset, all outputs SHALL be 0 except Inst_Ready=1.
REQ-028 Rst in any state SHALL abort the instruction with no Write_Reg and no Done, and Rst SHALL take priority over a simultaneous accept.

Configuration
REQ-029 Macro DP_SEQ_COND_EN SHALL control condition checking.
  - defined: all 16 ARM conditions are evaluated per REQ-017 (1111 treated as fail).
  - undefined: every instruction executes as AL, the NZCV input is unused, and no skip path exists.

Verification
REQ-030 The bench SHALL drive Inst=0xE2921005 (ADDS R1,R2,#5) and check ALU_OP=0100, Op_Sel=1, Imm32=5, SHIFT_OP=011, Shift_Num=0, LF=1 and S=1 in EXEC, and Write_Reg=1, Rd_Addr=1 and Done in WB.
REQ-031 The bench SHALL drive Inst=0xE1530004 (CMP R3,R4) and check S=1 in EXEC and Write_Reg=0 with Done=1 in WB.
REQ-032 The bench SHALL drive Inst=0xE0810312 with Rs_Data=0x00000105 in READ and check SHIFT_OP=100, Shift_Num=0x05 and Rm_Addr=2.
REQ-033 With DP_SEQ_COND_EN defined, the bench SHALL drive Inst=0x13A00001 with NZCV=0100 and check Done in cycle 1, LF=0, Write_Reg=0 and Inst_Ready=1 in cycle 2; without the macro, the full 4-cycle sequence.
REQ-034 The bench SHALL drive Inst=0xE0000091 (MUL) and check an Illegal pulse in cycle 1 with no LF, S or Write_Reg.
REQ-035 The bench SHALL assert Rst during EXEC of an ADDS and check IDLE at the next edge, Write_Reg and Done never asserted, and Inst_Ready=1.
